// File: rtl/booth_sequencer.sv
// Booth multiplication sequencer with run-skipping for a shift-add datapath.
// Each RUN cycle locates the next bit transition in the shifted multiplier and
// issues a single add/subtract; runs of equal bits cost no extra cycles.
module booth_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  B,
    output logic          dp_rst,
    output logic          done,
    output logic          op,
    output logic [SW-1:0] shift_a,
    output logic [SW-1:0] shift_b,
    output logic          busy,
    output logic          result_valid,
    output logic [SW-1:0] op_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [SW-1:0] POS_END = SW'(N);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] pos_q, pos_d;
    logic          prev_q, prev_d;
    logic [SW-1:0] op_count_q, op_count_d;
    logic          dp_rst_q, busy_q, result_valid_q;

    logic          found_c;
    logic [SW-1:0] k_c;
    logic          kbit_c;

    // Find the lowest unconsumed bit of B that differs from the previous Booth bit.
    always_comb begin
        found_c = 1'b0;
        k_c     = '0;
        kbit_c  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_c && ((32'(pos_q) + i) < N) && (B[i] != prev_q)) begin
                found_c = 1'b1;
                k_c     = SW'(i);
                kbit_c  = B[i];
            end
        end
    end

    // Next-state logic and the combinational datapath controls.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        prev_d     = prev_q;
        op_count_d = op_count_q;
        done       = 1'b1;
        op         = 1'b1;
        shift_a    = '0;
        shift_b    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    pos_d      = '0;
                    prev_d     = 1'b0;
                    op_count_d = '0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (found_c) begin
                    done       = 1'b0;
                    op         = ~kbit_c;
                    shift_a    = pos_q + k_c;
                    shift_b    = k_c + SW'(1);
                    pos_d      = pos_q + k_c + SW'(1);
                    prev_d     = kbit_c;
                    op_count_d = op_count_q + SW'(1);
                    if (pos_d == POS_END) begin
                        state_d = S_FINISH;
                    end
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, Booth bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pos_q          <= '0;
            prev_q         <= 1'b0;
            op_count_q     <= '0;
            dp_rst_q       <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            prev_q         <= prev_d;
            op_count_q     <= op_count_d;
            dp_rst_q       <= (state_d != S_LOAD);
            busy_q         <= (state_d != S_IDLE);
            result_valid_q <= (state_d == S_FINISH);
        end
    end

    assign dp_rst       = dp_rst_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench: behavioural shift-add datapath around the sequencer,
// expected digit sequence and product derived from Booth recoding arithmetic.
module tb_booth_sequencer;

    localparam int unsigned N      = 4;
    localparam int unsigned SW     = 3;
    localparam int unsigned RW     = 2 * N;
    localparam int          BUDGET = 4 * N + 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  B;
    logic          dp_rst;
    logic          done;
    logic          op;
    logic [SW-1:0] shift_a;
    logic [SW-1:0] shift_b;
    logic          busy;
    logic          result_valid;
    logic [SW-1:0] op_count;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]  mc;
    logic [N-1:0]  mp;
    logic [N-1:0]  dp_a;
    logic [N-1:0]  dp_b;
    logic [RW-1:0] dp_res;
    logic [RW-1:0] a_ext;

    booth_sequencer #(.N(N), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .B            (B),
        .dp_rst       (dp_rst),
        .done         (done),
        .op           (op),
        .shift_a      (shift_a),
        .shift_b      (shift_b),
        .busy         (busy),
        .result_valid (result_valid),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: load on strobe, accumulate and shift when not held.
    assign B     = dp_b;
    assign a_ext = {{N{dp_a[N-1]}}, dp_a};
    always @(posedge clk) begin
        if (!dp_rst) begin
            dp_a   <= mc;
            dp_b   <= mp;
            dp_res <= '0;
        end else if (!done) begin
            if (op) dp_res <= dp_res + (a_ext << shift_a);
            else    dp_res <= dp_res - (a_ext << shift_a);
            dp_b <= dp_b >> shift_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One multiplication from an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] m,
                            input bit hold, input bit pulse);
        int eop[N];
        int esa[N];
        int esb[N];
        int ne = 0;
        int last = -1;
        bit prevb = 1'b0;
        int pa;
        int pm;
        int exp_lat;
        logic [RW-1:0] exp_res;
        int cyc = 0;
        int seen = 0;
        bit got_rv = 1'b0;

        for (int i = 0; i < int'(N); i++) begin
            if (m[i] != prevb) begin
                eop[ne] = int'(prevb);
                esa[ne] = i;
                esb[ne] = i - last;
                last = i;
                ne++;
            end
            prevb = m[i];
        end
        exp_lat = 2 + ne + ((last != int'(N) - 1) ? 1 : 0);
        pa = $signed(a);
        pm = $signed(m);
        exp_res = RW'(pa * pm);

        mc = a;
        mp = m;
        start = 1'b1;
        while (!got_rv && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("load_dp_rst", 32'(dp_rst), 0);
                check("load_busy", 32'(busy), 1);
                check("load_done", 32'(done), 1);
                if (!hold) start = 1'b0;
            end
            if (pulse) begin
                if (cyc == 2) start = 1'b1;
                else if (cyc == 3 && !hold) start = 1'b0;
            end
            if (!done) begin
                if (seen < ne) begin
                    check("op", 32'(op), eop[seen]);
                    check("shift_a", 32'(shift_a), esa[seen]);
                    check("shift_b", 32'(shift_b), esb[seen]);
                end else begin
                    check("extra_op", seen, ne);
                end
                seen++;
            end
            if (result_valid) got_rv = 1'b1;
        end
        check("rv_seen", 32'(got_rv), 1);
        check("latency", cyc, exp_lat);
        check("num_ops", seen, ne);
        check("result", 32'(dp_res), 32'(exp_res));
        check("op_count", 32'(op_count), ne);
        check("finish_busy", 32'(busy), 1);
        @(negedge clk);
        check("rv_pulse", 32'(result_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 1);
    endtask

    initial begin
        int w;
        rst   = 1'b1;
        start = 1'b0;
        mc    = '0;
        mp    = '0;
        repeat (3) @(negedge clk);
        check("rst_dp_rst", 32'(dp_rst), 1);
        check("rst_done", 32'(done), 1);
        check("rst_op", 32'(op), 1);
        check("rst_shift_a", 32'(shift_a), 0);
        check("rst_shift_b", 32'(shift_b), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_op_count", 32'(op_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases (multiplicand, multiplier).
        run_mult(4'b0011, 4'b0110, 1'b0, 1'b0);
        run_mult(4'b0101, 4'b1111, 1'b0, 1'b0);
        run_mult(4'b0111, 4'b0000, 1'b0, 1'b0);
        run_mult(4'b0111, 4'b1000, 1'b0, 1'b0);
        run_mult(4'b0111, 4'b0111, 1'b0, 1'b0);
        run_mult(4'b1000, 4'b1000, 1'b0, 1'b0);
        run_mult(4'b1111, 4'b0101, 1'b0, 1'b0);

        // Abort during RUN after the first op.
        mc = 4'b0011;
        mp = 4'b0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (done && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        check("abort_reached_op", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 1);
        check("abort_dp_rst", 32'(dp_rst), 1);
        check("abort_rv", 32'(result_valid), 0);
        check("abort_op_count", 32'(op_count), 0);
        @(negedge clk);
        check("abort_idle_rv", 32'(result_valid), 0);
        run_mult(4'b0011, 4'b0110, 1'b0, 1'b0);

        // start pulsed while busy is ignored.
        run_mult(4'b0101, 4'b0110, 1'b0, 1'b1);
        run_mult(4'b0111, 4'b0000, 1'b0, 1'b1);

        // Back-to-back runs with start held high.
        run_mult(4'b0011, 4'b0110, 1'b1, 1'b0);
        run_mult(4'b0111, 4'b0111, 1'b1, 1'b0);
        run_mult(4'b1101, 4'b1010, 1'b0, 1'b0);

        // Randomized operands and start behaviour.
        for (int t = 0; t < 40; t++) begin
            run_mult(N'($urandom), N'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        run_mult(N'($urandom), N'($urandom), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
